// File: rtl/systolic_os_array_if.sv
// Operand and result stream bundle for systolic_os_array.
// The master drives jobs and operand beats; the slave returns result rows.
interface systolic_os_array_if #(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+8,
  parameter int KW         = 9
);
  logic                           start;
  logic [KW-1:0]                  k_len;
  logic                           signed_mode;
  logic                           in_valid;
  logic                           in_ready;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] d_col;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] w_row;
  logic                           busy;
  logic                           out_valid;
  logic                           out_ready;
  logic [$clog2(ARRAY_SIZE)-1:0]  out_row_idx;
  logic [ARRAY_SIZE*ACC_WIDTH-1:0]  out_data;
  logic                           done;

  modport master (
    output start, k_len, signed_mode,
    output in_valid, d_col, w_row, out_ready,
    input  in_ready, busy, out_valid,
    input  out_row_idx, out_data, done
  );

  modport slave (
    input  start, k_len, signed_mode,
    input  in_valid, d_col, w_row, out_ready,
    output in_ready, busy, out_valid,
    output out_row_idx, out_data, done
  );
endinterface

// File: rtl/systolic_os_array.sv
// Output-stationary NxN MAC array with input skew, drain and row readout.
// Define SYSTOLIC_RELU_EN to clamp negative signed results to zero.
module systolic_os_array #(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_WIDTH = 8,
  parameter int K_MAX      = 256,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+8,
  parameter int KW         = $clog2(K_MAX+1)
) (
  input logic              clk,
  input logic              rst,
  systolic_os_array_if.slave bus
);
  localparam int N   = ARRAY_SIZE;
  localparam int DW  = DATA_WIDTH;
  localparam int AW  = ACC_WIDTH;
  localparam int IW  = $clog2(N);
  localparam int DCW = $clog2(2*N);
  localparam int PW  = 2*DW+2;

  typedef enum logic [1:0] {
    S_IDLE, S_LOAD, S_DRAIN, S_OUT
  } state_t;

  state_t          r_state;
  logic [KW-1:0]   r_klen;
  logic [KW-1:0]   r_cnt;
  logic [DCW-1:0]  r_dcnt;
  logic            r_sgn;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_done;
  logic [IW-1:0]   r_idx;
  logic [N*AW-1:0] r_out_data;

  logic w_clr;
  logic w_beat;
  logic w_adv;

  logic [DW-1:0] w_din [N];
  logic [DW-1:0] w_win [N];
  logic [DW-1:0] w_dsk [N];
  logic [DW-1:0] w_wsk [N];
  logic [DW-1:0] w_dfw [N][N-1];
  logic [DW-1:0] w_wfw [N-1][N];
  logic [AW-1:0] w_acc [N][N];

  logic [IW-1:0]   w_nidx;
  logic [N*AW-1:0] w_rd;

  function automatic logic [AW-1:0] mac_prod(
    input logic [DW-1:0] a,
    input logic [DW-1:0] b,
    input logic          sg
  );
    logic signed [PW-1:0] xa;
    logic signed [PW-1:0] xb;
    logic signed [PW-1:0] p;
    xa = PW'($signed({sg & a[DW-1], a}));
    xb = PW'($signed({sg & b[DW-1], b}));
    p  = xa * xb;
    return AW'(p);
  endfunction

  assign w_clr  = (r_state == S_IDLE) && bus.start
                  && (bus.k_len != '0);
  assign w_beat = r_in_ready && bus.in_valid;
  assign w_adv  = w_beat || (r_state == S_DRAIN);

  // Zero operands are injected while draining.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_din[i] = '0;
      w_win[i] = '0;
      if (w_beat) begin
        w_din[i] = bus.d_col[i*DW +: DW];
        w_win[i] = bus.w_row[i*DW +: DW];
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign w_dsk[i] = w_din[i];
      assign w_wsk[i] = w_win[i];
    end else begin : g_delay
      logic [DW-1:0] r_dsr [i];
      logic [DW-1:0] r_wsr [i];
      always_ff @(posedge clk) begin
        if (rst || w_clr) begin
          for (int s = 0; s < i; s++) begin
            r_dsr[s] <= '0;
            r_wsr[s] <= '0;
          end
        end else if (w_adv) begin
          r_dsr[0] <= w_din[i];
          r_wsr[0] <= w_win[i];
          for (int s = 1; s < i; s++) begin
            r_dsr[s] <= r_dsr[s-1];
            r_wsr[s] <= r_wsr[s-1];
          end
        end
      end
      assign w_dsk[i] = r_dsr[i-1];
      assign w_wsk[i] = r_wsr[i-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_pe
      logic [DW-1:0] w_a;
      logic [DW-1:0] w_b;
      logic [AW-1:0] r_acc;

      if (j == 0) begin : g_al
        assign w_a = w_dsk[i];
      end else begin : g_ai
        assign w_a = w_dfw[i][j-1];
      end
      if (i == 0) begin : g_bt
        assign w_b = w_wsk[j];
      end else begin : g_bi
        assign w_b = w_wfw[i-1][j];
      end

      always_ff @(posedge clk) begin
        if (rst || w_clr)
          r_acc <= '0;
        else if (w_adv)
          r_acc <= r_acc + mac_prod(w_a, w_b, r_sgn);
      end
      assign w_acc[i][j] = r_acc;

      if (j < N-1) begin : g_df
        logic [DW-1:0] r_d;
        always_ff @(posedge clk) begin
          if (rst || w_clr) r_d <= '0;
          else if (w_adv)   r_d <= w_a;
        end
        assign w_dfw[i][j] = r_d;
      end
      if (i < N-1) begin : g_wf
        logic [DW-1:0] r_w;
        always_ff @(posedge clk) begin
          if (rst || w_clr) r_w <= '0;
          else if (w_adv)   r_w <= w_b;
        end
        assign w_wfw[i][j] = r_w;
      end
    end
  end

  // Row to load next: row 0 on entry, else the successor.
  assign w_nidx = r_out_valid ? r_idx + IW'(1) : '0;

  always_comb begin
    w_rd = '0;
    for (int j = 0; j < N; j++) begin
      w_rd[j*AW +: AW] = w_acc[w_nidx][j];
`ifdef SYSTOLIC_RELU_EN
      if (r_sgn && w_acc[w_nidx][j][AW-1])
        w_rd[j*AW +: AW] = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_klen      <= '0;
      r_cnt       <= '0;
      r_dcnt      <= '0;
      r_sgn       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_idx       <= '0;
      r_out_data  <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_clr) begin
            r_state    <= S_LOAD;
            r_klen     <= bus.k_len;
            r_sgn      <= bus.signed_mode;
            r_cnt      <= '0;
            r_in_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          if (bus.in_valid) begin
            if (r_cnt == r_klen - KW'(1)) begin
              r_state    <= S_DRAIN;
              r_in_ready <= 1'b0;
              r_dcnt     <= '0;
            end else begin
              r_cnt <= r_cnt + KW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (r_dcnt == DCW'(2*N-2))
            r_state <= S_OUT;
          else
            r_dcnt <= r_dcnt + DCW'(1);
        end
        S_OUT: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_idx       <= '0;
            r_out_data  <= w_rd;
          end else if (bus.out_ready) begin
            if (r_idx == IW'(N-1)) begin
              r_state     <= S_IDLE;
              r_out_valid <= 1'b0;
              r_done      <= 1'b1;
              r_idx       <= '0;
            end else begin
              r_idx      <= r_idx + IW'(1);
              r_out_data <= w_rd;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.out_valid   = r_out_valid;
  assign bus.out_row_idx = r_idx;
  assign bus.out_data    = r_out_data;
  assign bus.done        = r_done;
endmodule
